rr_sel_arbiter8: RTL and testbench
==================================

Name: rr_sel_arbiter8

Overview:
- Round-robin arbiter that sits directly upstream of the team's 8:1 3-bit data multiplexer.
- It arbitrates among 8 requesting sources and drives the mux select (sel[2:0]) plus a one-hot grant.
- It holds the selection stable under a valid/ready handshake with the downstream consumer.
- The mux output is valid exactly while out_valid is high.

Parameters:
- N_SRC, 8, number of requesting sources (fixed at 8; select width tied to it).
- IDX_W, 3, width of sel and of the round-robin pointer.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  per-source request; bit i = source i wants the mux.
- out_ready  input  1  downstream accepts the currently selected word this cycle.
- sel  output  3  registered mux select (index of granted source).
- gnt  output  8  registered one-hot grant; equals 1<<sel while out_valid, else 0.
- out_valid  output  1  registered; selected word on the mux output is valid.

Behaviour:
- Reset (async, immediate, including mid-grant):
  - sel=0, gnt=0, out_valid=0, ptr=0, state=IDLE.
  - No transfer is counted for the interrupted grant.
- ptr (3-bit, internal) is the highest-priority index. The search order is ptr, ptr+1, ..., ptr+7, all mod 8.
- State IDLE:
  - If req!=0, pick the first set bit in search order.
  - Next edge: sel=idx, gnt=1<<idx, out_valid=1, state=GRANT.
  - Latency from req high (sampled) to out_valid is 1 cycle.
  - If req==0, stay IDLE with outputs at reset values.
- State GRANT:
  - While out_ready=0 and req[sel]=1: sel, gnt and out_valid are held unchanged. New requests from other sources have no effect.
  - Transfer (out_valid=1 and out_ready=1): ptr <= sel+1 (7 wraps to 0), so the just-served source becomes lowest priority.
  - In the same cycle, the arbiter re-arbitrates on the current req using the updated ptr:
    - If any req is set: stay GRANT, load the new sel/gnt, out_valid stays 1. This is back-to-back, one transfer per cycle.
    - If req==0: go to IDLE, out_valid=0, gnt=0, sel holds its last value.
  - If the sole remaining requester is the one just served, it is re-granted (sel unchanged).
  - Abort: req[sel]=0 while out_ready=0 → next edge out_valid=0, gnt=0, state=IDLE, ptr unchanged.
  - Transfer takes precedence over abort: if out_ready=1, the transfer completes regardless of req[sel].
- sel changes only on an IDLE→GRANT entry or on a transfer. It is never changed while out_valid=1 and out_ready=0.
- All outputs come straight from flops; there is no combinational path from req or out_ready to any output.

Decomposition:
- Shared package holds:
  - constants N_SRC=8, IDX_W=3;
  - the state enum {IDLE, GRANT};
  - the reset value of ptr (0).
- One combinational sub-module, rr_pick8:
  - inputs: req[7:0], ptr[2:0];
  - outputs: found, idx[2:0];
  - function: rotating priority search, reused for both the IDLE and the GRANT re-arbitration paths.
- The top level contains the state register, ptr, and the output registers.

Test Plan:
- Reset: assert rst asynchronously mid-cycle while in GRANT with sel=5 → sel=0, gnt=0x00, out_valid=0 immediately. After release with req=0x00 → outputs stay at reset values.
- Single request: req=0x20, out_ready=1 from reset → next cycle out_valid=1, sel=5, gnt=0x20. Drop req the same cycle → following cycle out_valid=0; internal ptr=6 (check via next grant order).
- Full load fairness: req=0xFF, out_ready=1 continuously from reset → sel sequence 0,1,2,3,4,5,6,7,0,... one per cycle, with out_valid continuously 1.
- Wrap and two sources: req=0x81, out_ready=1 → sel sequence 0,7,0,7. Then req=0x80 only, after a grant of 7 → 7 is re-granted back-to-back.
- Backpressure: req=0x08, out_ready=0 for 4 cycles, with req[1] raised in cycle 2 → sel=3, gnt=0x08 stable for all 4 cycles. Set out_ready=1 → next sel=1 (ptr=4 search wraps to 1).
- Abort: req=0x08 granted, out_ready=0, then req=0x00 → next cycle out_valid=0, gnt=0. Then req=0x18 → next grant sel=3 (ptr unchanged, still 0→3 first).

Source files
------------

// File: rtl/rr_sel_arbiter8_pkg.sv
// rr_sel_arbiter8_pkg: shared constants and state type for the round-robin mux arbiter
package rr_sel_arbiter8_pkg;
  localparam int N_SRC = 8;
  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] PTR_RST = '0;
  typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/rr_sel_arbiter8_pick.sv
// rr_pick8: rotating-priority search, first set bit of req starting at ptr
module rr_pick8
  import rr_sel_arbiter8_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);
  logic [N_SRC-1:0] rot;
  logic [IDX_W-1:0] off;
  assign rot = N_SRC'({req, req} >> ptr);
  assign found = |req;
  assign idx = ptr + off;
  always_comb begin
    off = '0;
    for (int i = N_SRC - 1; i >= 0; i--) off = rot[i] ? IDX_W'(i) : off;
  end
endmodule

// File: rtl/rr_sel_arbiter8.sv
// rr_sel_arbiter8: round-robin arbiter driving an 8:1 mux select under valid/ready
module rr_sel_arbiter8
  import rr_sel_arbiter8_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] req,
  input  logic             out_ready,
  output logic [IDX_W-1:0] sel,
  output logic [N_SRC-1:0] gnt,
  output logic             out_valid
);
  state_t state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n, idx, sel_n;
  logic [N_SRC-1:0] gnt_n;
  logic found, go, hold;
  rr_pick8 u_pick (.req(req), .ptr(ptr_n), .found(found), .idx(idx));
  // In GRANT, out_ready means a transfer: advance ptr then re-arbitrate the same cycle
  always_comb begin
    ptr_n = (state == GRANT && out_ready) ? sel + IDX_W'(1) : ptr;
    go = (state == IDLE || out_ready) && found;
    hold = state == GRANT && !out_ready && req[sel];
    state_n = (go || hold) ? GRANT : IDLE;
    sel_n = go ? idx : sel;
    gnt_n = go ? N_SRC'(1) << idx : hold ? gnt : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= PTR_RST;
      sel <= '0;
      gnt <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      sel <= sel_n;
      gnt <= gnt_n;
      out_valid <= go || hold;
    end
  end
endmodule

// File: tb/tb_rr_sel_arbiter8.sv
// tb_rr_sel_arbiter8: vector table, directed corner cases and random run against a reference model
module tb_rr_sel_arbiter8;
  logic clk = 0, rst = 1, out_ready = 0, out_valid;
  logic [7:0] req = 0, gnt;
  logic [2:0] sel;
  int total = 0, bad = 0;
  int m_ptr, m_sel;
  bit m_valid;

  typedef struct {
    bit rst_b;
    logic [7:0] req;
    bit rdy;
    logic [2:0] sel;
    logic [7:0] gnt;
    bit v;
  } vec_t;
  vec_t tbl[$];

  rr_sel_arbiter8 dut (.clk(clk), .rst(rst), .req(req), .out_ready(out_ready),
                       .sel(sel), .gnt(gnt), .out_valid(out_valid));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_ptr = 0;
    m_sel = 0;
    m_valid = 0;
  endfunction

  // One clock of the arbiter rules: serve, rotate priority, then search or hold/abort
  function automatic void model_step(input logic [7:0] r, input bit rdy);
    bit hit;
    if (m_valid && rdy) m_ptr = (m_sel + 1) % 8;
    if (!m_valid || rdy) begin
      hit = 0;
      for (int k = 0; k < 8; k++)
        if (!hit && r[(m_ptr + k) % 8]) begin
          hit = 1;
          m_sel = (m_ptr + k) % 8;
        end
      m_valid = hit;
    end else if (!r[m_sel]) m_valid = 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    model_step(req, out_ready);
  endtask

  task automatic do_reset();
    rst = 1;
    req = 0;
    out_ready = 0;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask

  task automatic chk_model(input string nm);
    chk({nm, ".sel"}, 32'(sel), 32'(m_sel));
    chk({nm, ".gnt"}, 32'(gnt), m_valid ? 32'(1) << m_sel : 32'd0);
    chk({nm, ".valid"}, 32'(out_valid), 32'(m_valid));
  endtask

  initial begin
    tbl.push_back('{1, 8'h20, 1, 3'd5, 8'h20, 1});
    tbl.push_back('{0, 8'h00, 1, 3'd5, 8'h00, 0});
    tbl.push_back('{0, 8'h60, 0, 3'd6, 8'h40, 1});
    tbl.push_back('{0, 8'h60, 1, 3'd5, 8'h20, 1});
    tbl.push_back('{0, 8'h00, 1, 3'd5, 8'h00, 0});
    for (int i = 0; i < 10; i++)
      tbl.push_back('{i == 0, 8'hFF, 1, 3'(i), 8'h01 << (i % 8), 1});
    tbl.push_back('{1, 8'h81, 1, 3'd0, 8'h01, 1});
    tbl.push_back('{0, 8'h81, 1, 3'd7, 8'h80, 1});
    tbl.push_back('{0, 8'h81, 1, 3'd0, 8'h01, 1});
    tbl.push_back('{0, 8'h81, 1, 3'd7, 8'h80, 1});
    tbl.push_back('{0, 8'h80, 1, 3'd7, 8'h80, 1});
    tbl.push_back('{0, 8'h80, 1, 3'd7, 8'h80, 1});
    tbl.push_back('{0, 8'h00, 1, 3'd7, 8'h00, 0});
    tbl.push_back('{1, 8'h08, 0, 3'd3, 8'h08, 1});
    tbl.push_back('{0, 8'h08, 0, 3'd3, 8'h08, 1});
    tbl.push_back('{0, 8'h0A, 0, 3'd3, 8'h08, 1});
    tbl.push_back('{0, 8'h0A, 0, 3'd3, 8'h08, 1});
    tbl.push_back('{0, 8'h0A, 1, 3'd1, 8'h02, 1});
    tbl.push_back('{0, 8'h00, 1, 3'd1, 8'h00, 0});
    tbl.push_back('{1, 8'h08, 0, 3'd3, 8'h08, 1});
    tbl.push_back('{0, 8'h00, 0, 3'd3, 8'h00, 0});
    tbl.push_back('{0, 8'h18, 0, 3'd3, 8'h08, 1});

    #1;
    chk("rst.sel", 32'(sel), 0);
    chk("rst.gnt", 32'(gnt), 0);
    chk("rst.valid", 32'(out_valid), 0);

    foreach (tbl[i]) begin
      if (tbl[i].rst_b) do_reset();
      req = tbl[i].req;
      out_ready = tbl[i].rdy;
      step();
      chk($sformatf("vec%0d.sel", i), 32'(sel), 32'(tbl[i].sel));
      chk($sformatf("vec%0d.gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("vec%0d.valid", i), 32'(out_valid), 32'(tbl[i].v));
      chk($sformatf("vec%0d.model", i), 32'(sel), 32'(m_sel));
    end

    // Asynchronous reset asserted mid-cycle while granted to source 5
    do_reset();
    req = 8'h20;
    out_ready = 0;
    step();
    chk("async.pre_sel", 32'(sel), 5);
    #3;
    rst = 1;
    #1;
    chk("async.sel", 32'(sel), 0);
    chk("async.gnt", 32'(gnt), 0);
    chk("async.valid", 32'(out_valid), 0);
    req = 0;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    step();
    step();
    chk("async.idle_sel", 32'(sel), 0);
    chk("async.idle_gnt", 32'(gnt), 0);
    chk("async.idle_valid", 32'(out_valid), 0);

    // Random traffic against the reference model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      req = (c % 3 == 0) ? 8'($urandom) & 8'($urandom) & 8'($urandom) : 8'($urandom);
      if (c % 50 == 7) req = 0;
      out_ready = $urandom_range(0, 2) != 0;
      step();
      chk_model($sformatf("rand%0d", c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
